// File: rtl/qsys_system_pio_key_in.sv
// Avalon-MM input PIO: synchronises and optionally debounces a key/switch bus,
// latches selected edges into a write-1-to-clear capture register and raises a maskable irq.
module qsys_system_pio_key_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_strobe;

  // Only the low WIDTH bits of a write are meaningful; the rest are dropped.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or posedge reset) begin
        if (reset) stable <= '0;
        else       stable <= sync;
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CNT_W-1:0] db_cnt;

      // A bit flips only after N consecutive cycles of disagreement with the accepted level.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stable <= '0;
          db_cnt <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
              db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
              stable[i] <= sync[i];
              db_cnt[i] <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  endgenerate

  assign rise     = stable & ~prev;
  assign fall     = ~stable & prev;
  assign edge_det = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall : (rise | fall);

  assign wr_strobe = chipselect & ~write_n;
  assign cap_clr   = (wr_strobe && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge beats a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
    end else begin
      prev         <= stable;
      edge_capture <= (edge_capture & ~cap_clr) | edge_det;
      if (wr_strobe && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
      irq          <= |(edge_capture & irq_mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        3'd0:    readdata <= 32'(stable);
        3'd2:    readdata <= 32'(irq_mask);
        3'd3:    readdata <= 32'(edge_capture);
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_system_pio_key_in.sv
// Bench for the input PIO: a bypass/falling-edge instance and a debounced/any-edge instance
// share one bus and are checked every cycle against a behavioural model plus literal checks.
module tb_qsys_system_pio_key_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  qsys_system_pio_key_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) dut_n0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

  qsys_system_pio_key_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) dut_n8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));

  // Model: index 0 = no debounce / falling edges, index 1 = 8-sample debounce / any edge.
  logic [3:0]  m_s1[2], m_s2[2], m_stable[2], m_prev[2], m_mask[2], m_cap[2];
  logic        m_irq[2];
  logic [31:0] m_rd[2];
  logic [3:0]  m_sh[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_s1[d] = '0; m_s2[d] = '0; m_stable[d] = '0; m_prev[d] = '0;
        m_mask[d] = '0; m_cap[d] = '0; m_irq[d] = 1'b0; m_rd[d] = '0;
      end
      m_sh.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] sync_old, st_new, chg, clr;
        logic       wr, all_diff;
        wr = chipselect && !write_n;
        sync_old = m_s2[d];
        if (d == 0) begin
          st_new = sync_old;
        end else begin
          m_sh.push_back(sync_old);
          if (m_sh.size() > 8) void'(m_sh.pop_front());
          st_new = m_stable[1];
          if (m_sh.size() == 8) begin
            for (int b = 0; b < 4; b++) begin
              all_diff = 1'b1;
              foreach (m_sh[j]) if (m_sh[j][b] == m_stable[1][b]) all_diff = 1'b0;
              if (all_diff) st_new[b] = ~m_stable[1][b];
            end
          end
        end
        chg = (d == 0) ? (m_prev[d] & ~m_stable[d]) : (m_prev[d] ^ m_stable[d]);
        clr = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
        case (address)
          3'd0:    m_rd[d] = {28'h0, m_stable[d]};
          3'd2:    m_rd[d] = {28'h0, m_mask[d]};
          3'd3:    m_rd[d] = {28'h0, m_cap[d]};
          default: m_rd[d] = 32'h0;
        endcase
        m_irq[d] = (m_cap[d] & m_mask[d]) != 4'h0;
        m_cap[d] = (m_cap[d] & ~clr) | chg;
        if (wr && address == 3'd2) m_mask[d] = writedata[3:0];
        m_prev[d]   = m_stable[d];
        m_stable[d] = st_new;
        m_s2[d]     = m_s1[d];
        m_s1[d]     = in_port;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("model_rd_n0", rd0, m_rd[0]);
      check("model_irq_n0", {31'h0, irq0}, {31'h0, m_irq[0]});
      check("model_rd_n8", rd1, m_rd[1]);
      check("model_irq_n8", {31'h0, irq1}, {31'h0, m_irq[1]});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] data);
    address = a; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;

    // Idle: every address reads zero, no interrupt.
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("idle_rd_n0", rd0, 32'h0);
      check("idle_rd_n8", rd1, 32'h0);
    end
    tick(12);
    check("idle_irq_n0", {31'h0, irq0}, 32'h0);
    check("idle_irq_n8", {31'h0, irq1}, 32'h0);

    // Data path through the undebounced instance.
    address = 3'd0;
    in_port = 4'b1010;
    tick(5);
    check("data_A_n0", rd0, 32'h0000000A);
    in_port = 4'b0101;
    tick(5);
    check("data_5_n0", rd0, 32'h00000005);
    tick(20);

    // Falling capture and irq.
    wr(3'd3, 32'hF);
    wr(3'd2, 32'hFFFF_FFFF);
    in_port = 4'hF;
    tick(25);
    wr(3'd3, 32'hF);
    rd(3'd2);
    check("mask_read_n0", rd0, 32'h0000000F);
    in_port = 4'hE;
    address = 3'd3;
    tick(6);
    check("fall_cap_n0", rd0, 32'h1);
    check("fall_irq_n0", {31'h0, irq0}, 32'h1);
    wr(3'd3, 32'h0);
    tick();
    check("clr0_keep_n0", rd0, 32'h1);
    check("clr0_irq_n0", {31'h0, irq0}, 32'h1);
    wr(3'd3, 32'h1);
    tick();
    check("clr1_cap_n0", rd0, 32'h0);
    check("clr1_irq_n0", {31'h0, irq0}, 32'h0);

    // Mask gating on bit 2.
    wr(3'd2, 32'h0);
    in_port = 4'hA;
    address = 3'd3;
    tick(6);
    check("gate_cap_n0", rd0, 32'h4);
    check("gate_irq_n0", {31'h0, irq0}, 32'h0);
    wr(3'd2, 32'h4);
    check("gate_irq_same_n0", {31'h0, irq0}, 32'h0);
    tick();
    check("gate_irq_next_n0", {31'h0, irq0}, 32'h1);
    tick(20);

    // Falling edge on bit 0 coincides with a clear of bit 0.
    in_port = 4'hB;
    tick(6);
    in_port = 4'hA;
    tick(3);
    wr(3'd3, 32'h1);
    rd(3'd3);
    check("collide_cap_n0", rd0, 32'h5);
    tick(25);

    // Debounce: a 5-cycle glitch is filtered, an 8-cycle pulse is accepted.
    wr(3'd3, 32'hF);
    address = 3'd0;
    in_port = 4'h8;
    tick(5);
    in_port = 4'hA;
    tick(25);
    rd(3'd0);
    check("glitch_data_n8", rd1, 32'hA);
    rd(3'd3);
    check("glitch_cap_n8", rd1, 32'h0);
    address = 3'd0;
    in_port = 4'h8;
    tick(8);
    in_port = 4'hA;
    tick(3);
    check("pulse_data_n8", rd1, 32'h8);
    address = 3'd3;
    tick();
    check("pulse_cap_n8", rd1, 32'h2);
    tick(20);

    // Asynchronous reset in the middle of a debounce count.
    wr(3'd2, 32'hF);
    tick();
    check("pre_rst_irq_n8", {31'h0, irq1}, 32'h1);
    in_port = 4'h8;
    tick(4);
    #3 reset = 1'b1;
    #1;
    check("rst_rd_n0", rd0, 32'h0);
    check("rst_irq_n0", {31'h0, irq0}, 32'h0);
    check("rst_rd_n8", rd1, 32'h0);
    check("rst_irq_n8", {31'h0, irq1}, 32'h0);
    tick(2);
    reset = 1'b0;
    address = 3'd3;
    tick(30);
    check("post_rst_cap_n8", rd1, 32'h8);
    check("post_rst_cap_n0", rd0, 32'h0);
    check("post_rst_irq_n8", {31'h0, irq1}, 32'h0);
    rd(3'd0);
    check("post_rst_data_n0", rd0, 32'h8);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
